time_of_day_counter: RTL
========================

# time_of_day_counter

Parametrised hour:minute:second time-of-day counter for the digital clock datapath. It advances one second per qualified `tick`, not per clock edge, and supports run/pause and a validated runtime time-set. It also provides a 12-hour display view, one-cycle rollover pulses for downstream blocks (date/day logic) and an hour:minute alarm match. It sits between the seconds-tick divider and the display/alarm formatting logic.

## Interface
- `HOURS`, 24, hours per day; hour counts 0..HOURS-1
- `MINS`, 60, minutes per hour
- `SECS`, 60, seconds per minute
- `HW`, 5, hour field width; must hold HOURS-1
- `MW`, 6, minute field width; must hold MINS-1
- `SW`, 6, second field width; must hold SECS-1
- `slowclk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `tick`  in  1  advance one second on this edge (qualified by `run`)
- `run`  in  1  1 = count, 0 = hold
- `set_en`  in  1  load `set_h/set_m/set_s` this edge
- `set_h`  in  HW; `set_m`  in  MW; `set_s`  in  SW  time to load
- `mode_12h`  in  1  display format select
- `alarm_en`  in  1  alarm compare enable
- `alarm_h`  in  HW; `alarm_m`  in  MW  alarm time
- `hour`  out  HW; `min`  out  MW; `sec`  out  SW  current 24h-style time, registered
- `disp_hour`  out  HW  display hour
- `pm`  out  1  afternoon flag
- `sec_wrap`, `min_wrap`, `day_wrap`  out  1  one-cycle rollover pulses
- `set_err`  out  1  one-cycle pulse, rejected set
- `alarm_hit`  out  1  one-cycle alarm pulse

## Operation
- Reset: `hour`=`min`=`sec`=0; all pulse outputs 0. `disp_hour` and `pm` follow the combinational rules below (12 and 0 in 12h mode, 0 and 0 in 24h mode).
- Per-edge priority: `set_en` > (`tick` & `run`) > hold.
- Set path:
  - Accepted only if `set_h`<HOURS, `set_m`<MINS and `set_s`<SECS. Fields load atomically.
  - An out-of-range request leaves the time unchanged and pulses `set_err`.
  - Any `tick` in a `set_en` cycle is discarded, whether or not the set is accepted.
  - A set never produces wrap pulses or `alarm_hit`.
- Count path (`tick`&`run`&!`set_en`):
  - If `sec`<SECS-1, then `sec`+1.
  - Otherwise `sec`=0 and `sec_wrap`=1. Then, if `min`<MINS-1, `min`+1; otherwise `min`=0 and `min_wrap`=1. Then, if `hour`<HOURS-1, `hour`+1; otherwise `hour`=0 and `day_wrap`=1.
  - `day_wrap` implies `min_wrap`, which implies `sec_wrap`, in the same cycle.
- `tick` while `run`=0: ignored, not queued.
- Comparisons use full field width. Out-of-range internal values cannot occur, because set is validated.
- Display, combinational from the registered `hour`:
  - When `mode_12h`=1 and HOURS=24: `pm` = (`hour`>=12). `disp_hour` = 12 if `hour` mod 12 = 0, else `hour` mod 12.
  - Otherwise: `disp_hour`=`hour` and `pm`=0.
- Alarm: `alarm_hit` pulses when a count-path update produces `hour`=`alarm_h`, `min`=`alarm_m`, `sec`=0 with `alarm_en`=1, all sampled on that edge. It fires once per match; holding at the match time does not re-fire.

## Timing
- `hour`, `min`, `sec`, wrap pulses, `set_err` and `alarm_hit` are all registered. They are valid the cycle after the edge that sampled `tick`/`set_en`.
- Pulses are high exactly one cycle, then return to 0 unless re-triggered on the next edge.
- Back-to-back `tick` on consecutive edges advances one second per edge, with no dead cycle.
- `disp_hour`/`pm` change in the same cycle as `hour` or `mode_12h`, with zero added latency.
- `reset` asserted mid-operation clears the state and pulses immediately, without waiting for a clock edge. The first count occurs on the first `tick`&`run` edge after `reset` deasserts.

## Test plan
- Reset, then 61 ticks with `run`=1: time reads 00:01:01. `sec_wrap` is high one cycle after tick 60; `min_wrap` and `day_wrap` stay 0.
- Set 23:59:59, then one tick: time reads 00:00:00 with `sec_wrap`, `min_wrap` and `day_wrap` all high for that one cycle.
- `set_en` with `set_m`=60 (and a tick in the same cycle): time unchanged, `set_err`=1 for one cycle, no wrap pulse.
- Set 13:05:00 with `mode_12h`=1: `disp_hour`=1, `pm`=1. Set 00:10:00: `disp_hour`=12, `pm`=0. With `mode_12h`=0: `disp_hour`=0.
- Alarm 07:30 with `alarm_en`=1, set 07:29:59, tick: `alarm_hit` pulses once. Ticks toggling with `run`=0 produce no change. Setting directly to 07:30:00 produces no `alarm_hit`.
- Assert `reset` asynchronously mid-count at 12:34:56: outputs read 0 before the next `slowclk` edge, and counting resumes from 00:00:00.

Source files
------------

// File: rtl/time_of_day_counter.sv
// Hour:minute:second time-of-day counter advanced by a qualified seconds tick,
// with validated runtime set, 12-hour display view, rollover pulses and alarm match.
module time_of_day_counter #(
    parameter int HOURS = 24,
    parameter int MINS  = 60,
    parameter int SECS  = 60,
    parameter int HW    = 5,
    parameter int MW    = 6,
    parameter int SW    = 6
) (
    input  logic          slowclk,
    input  logic          reset,
    input  logic          tick,
    input  logic          run,
    input  logic          set_en,
    input  logic [HW-1:0] set_h,
    input  logic [MW-1:0] set_m,
    input  logic [SW-1:0] set_s,
    input  logic          mode_12h,
    input  logic          alarm_en,
    input  logic [HW-1:0] alarm_h,
    input  logic [MW-1:0] alarm_m,
    output logic [HW-1:0] hour,
    output logic [MW-1:0] min,
    output logic [SW-1:0] sec,
    output logic [HW-1:0] disp_hour,
    output logic          pm,
    output logic          sec_wrap,
    output logic          min_wrap,
    output logic          day_wrap,
    output logic          set_err,
    output logic          alarm_hit
);

    localparam logic [HW-1:0] HOUR_MAX  = HW'(HOURS - 1);
    localparam logic [MW-1:0] MIN_MAX   = MW'(MINS - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(SECS - 1);
    localparam logic [HW:0]   HOUR_LIM  = (HW + 1)'(HOURS);
    localparam logic [MW:0]   MIN_LIM   = (MW + 1)'(MINS);
    localparam logic [SW:0]   SEC_LIM   = (SW + 1)'(SECS);
    localparam logic [HW-1:0] HOUR_NOON = HW'(12);
    localparam logic [HW-1:0] HOUR_ZERO = HW'(0);
    localparam logic [MW-1:0] MIN_ZERO  = MW'(0);
    localparam logic [SW-1:0] SEC_ZERO  = SW'(0);
    localparam bit            IS_24H    = (HOURS == 24);

    logic [HW-1:0] hour_q, hour_d;
    logic [MW-1:0] min_q, min_d;
    logic [SW-1:0] sec_q, sec_d;
    logic          sec_wrap_q, sec_wrap_d;
    logic          min_wrap_q, min_wrap_d;
    logic          day_wrap_q, day_wrap_d;
    logic          set_err_q, set_err_d;
    logic          alarm_hit_q, alarm_hit_d;

    logic          set_ok_s;
    logic          count_s;
    logic [HW-1:0] hour_mod_s;
    logic [HW-1:0] disp_hour_s;
    logic          pm_s;

    // Set request validation; one extra bit keeps the limit compare exact at full field width.
    always_comb begin
        set_ok_s = ({1'b0, set_h} < HOUR_LIM) &&
                   ({1'b0, set_m} < MIN_LIM)  &&
                   ({1'b0, set_s} < SEC_LIM);
    end

    // A count step needs a qualified tick and no competing set this edge.
    always_comb begin
        count_s = tick && run && !set_en;
    end

    // Next-state: set beats count beats hold; carries ripple sec -> min -> hour.
    always_comb begin
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        sec_wrap_d  = 1'b0;
        min_wrap_d  = 1'b0;
        day_wrap_d  = 1'b0;
        set_err_d   = 1'b0;
        alarm_hit_d = 1'b0;
        if (set_en) begin
            if (set_ok_s) begin
                hour_d = set_h;
                min_d  = set_m;
                sec_d  = set_s;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (count_s) begin
            if (sec_q < SEC_MAX) begin
                sec_d = sec_q + SW'(1);
            end else begin
                sec_d      = SEC_ZERO;
                sec_wrap_d = 1'b1;
                if (min_q < MIN_MAX) begin
                    min_d = min_q + MW'(1);
                end else begin
                    min_d      = MIN_ZERO;
                    min_wrap_d = 1'b1;
                    if (hour_q < HOUR_MAX) begin
                        hour_d = hour_q + HW'(1);
                    end else begin
                        hour_d     = HOUR_ZERO;
                        day_wrap_d = 1'b1;
                    end
                end
            end
            // Only a counted arrival at hh:mm:00 fires, so holding or setting never re-triggers.
            alarm_hit_d = alarm_en && (hour_d == alarm_h) && (min_d == alarm_m) &&
                          (sec_d == SEC_ZERO);
        end else begin
            hour_d = hour_q;
        end
    end

    // Time and pulse registers with asynchronous clear.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            hour_q      <= HOUR_ZERO;
            min_q       <= MIN_ZERO;
            sec_q       <= SEC_ZERO;
            sec_wrap_q  <= 1'b0;
            min_wrap_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            set_err_q   <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_wrap_q  <= sec_wrap_d;
            min_wrap_q  <= min_wrap_d;
            day_wrap_q  <= day_wrap_d;
            set_err_q   <= set_err_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    // 12-hour view: fold afternoon hours down, and show midnight/noon as 12.
    always_comb begin
        if (hour_q >= HOUR_NOON) begin
            hour_mod_s = hour_q - HOUR_NOON;
        end else begin
            hour_mod_s = hour_q;
        end
        if (mode_12h && IS_24H) begin
            pm_s = (hour_q >= HOUR_NOON);
            if (hour_mod_s == HOUR_ZERO) begin
                disp_hour_s = HOUR_NOON;
            end else begin
                disp_hour_s = hour_mod_s;
            end
        end else begin
            pm_s        = 1'b0;
            disp_hour_s = hour_q;
        end
    end

    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign sec_wrap  = sec_wrap_q;
    assign min_wrap  = min_wrap_q;
    assign day_wrap  = day_wrap_q;
    assign set_err   = set_err_q;
    assign alarm_hit = alarm_hit_q;
    assign disp_hour = disp_hour_s;
    assign pm        = pm_s;

endmodule
